// File: rtl/bcd_conv_sched_if.sv
// Bundle of requester-side and shared-converter-side signals for the BCD conversion scheduler.
// The slave modport is the scheduler's view; the master modport drives requests and models the converter.
interface bcd_conv_sched_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 20
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] bin_in;
  logic [N_REQ-1:0]        ack;
  logic [23:0]             bcd_out;
  logic [ID_W-1:0]         bcd_id;
  logic                    bcd_valid;
  logic                    ovf;
  logic                    err;
  logic                    busy;
  logic                    conv_start;
  logic [DATA_W-1:0]       conv_data;
  logic                    conv_done;
  logic [23:0]             conv_bcd;

  modport master (
    output req, bin_in, conv_done, conv_bcd,
    input  ack, bcd_out, bcd_id, bcd_valid, ovf, err, busy, conv_start, conv_data
  );

  modport slave (
    input  req, bin_in, conv_done, conv_bcd,
    output ack, bcd_out, bcd_id, bcd_valid, ovf, err, busy, conv_start, conv_data
  );
endinterface

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one binary-to-BCD converter among N_REQ requesters,
// with operand saturation to 999999 and a converter timeout that returns 24'hFFFFFF.
module bcd_conv_sched #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 20,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_conv_sched_if.slave  io_if
);
  localparam int                ID_W    = $clog2(N_REQ);
  localparam int                CNT_W   = $clog2(TIMEOUT);
  localparam logic [DATA_W-1:0] DEC_MAX = DATA_W'(999999);
  localparam logic [23:0]       BCD_ERR = 24'hFFFFFF;

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_START, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_gnt;
  logic [ID_W-1:0]   w_winner;
  logic              w_found;
  logic [DATA_W-1:0] w_ops [N_REQ];
  logic [DATA_W-1:0] w_operand;
  logic              w_sat;
  logic [DATA_W-1:0] r_conv_data;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_timeout;
  logic [23:0]       r_bcd_out;
  logic [ID_W-1:0]   r_bcd_id;
  logic              r_ovf_out;
  logic              r_err_out;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ops
      assign w_ops[gi] = io_if.bin_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Scan downward so the requester closest to r_ptr is the last (winning) assignment.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (io_if.req[(int'(r_ptr) + k) % N_REQ]) begin
        w_found  = 1'b1;
        w_winner = ID_W'((int'(r_ptr) + k) % N_REQ);
      end
    end
  end

  assign w_operand = w_ops[w_winner];
  assign w_sat     = (w_operand > DEC_MAX);
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (|io_if.req) w_state_next = S_GRANT;
      S_GRANT: w_state_next = w_found ? S_START : S_IDLE;
      S_START: w_state_next = S_WAIT;
      S_WAIT:  if (io_if.conv_done || w_timeout) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Result registers load only on the WAIT->DONE edge so they hold between completions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_conv_data <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_bcd_out   <= '0;
      r_bcd_id    <= '0;
      r_ovf_out   <= 1'b0;
      r_err_out   <= 1'b0;
    end else begin
      case (r_state)
        S_GRANT: begin
          if (w_found) begin
            r_gnt       <= w_winner;
            r_conv_data <= w_sat ? DEC_MAX : w_operand;
            r_ovf       <= w_sat;
          end
        end
        S_START: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (io_if.conv_done || w_timeout) begin
            r_bcd_out <= io_if.conv_done ? io_if.conv_bcd : BCD_ERR;
            r_err_out <= ~io_if.conv_done;
            r_ovf_out <= r_ovf;
            r_bcd_id  <= r_gnt;
          end
        end
        S_DONE: r_ptr <= (r_gnt == ID_W'(N_REQ - 1)) ? '0 : r_gnt + ID_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    io_if.ack = '0;
    if (r_state == S_DONE) io_if.ack[r_gnt] = 1'b1;
  end

  assign io_if.bcd_valid  = (r_state == S_DONE);
  assign io_if.busy       = (r_state != S_IDLE);
  assign io_if.conv_start = (r_state == S_START);
  assign io_if.conv_data  = r_conv_data;
  assign io_if.bcd_out    = r_bcd_out;
  assign io_if.bcd_id     = r_bcd_id;
  assign io_if.ovf        = r_ovf_out;
  assign io_if.err        = r_err_out;
endmodule

// File: tb/tb_bcd_conv_sched.sv
// Scoreboard bench for bcd_conv_sched: requests push expected results, the monitor pops them
// on bcd_valid, and a behavioural converter answers conv_start after a programmable delay.
module tb_bcd_conv_sched;
  localparam int N_REQ   = 4;
  localparam int DATA_W  = 20;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic done_model;
  logic done_stim;

  always #5 clk = ~clk;

  bcd_conv_sched_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();
  assign bus.conv_done = done_model | done_stim;

  bcd_conv_sched #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_if (bus.slave)
  );

  typedef struct {
    int          id;
    logic [23:0] bcd;
    int          ovf;
    int          err;
    int          op;
  } exp_t;

  exp_t sb[$];
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   n_valid    = 0;
  int   last_op    = 0;
  int   conv_delay = 1;
  int   silent_req = 0;
  int   stray_req  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int value);
    logic [23:0] r;
    int v;
    v = value;
    r = '0;
    for (int d = 0; d < 6; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic void push_exp(input int id, input int operand, input int timeout);
    exp_t e;
    int sat;
    sat   = (operand > 999999) ? 999999 : operand;
    e.id  = id;
    e.op  = sat;
    e.ovf = (operand > 999999) ? 1 : 0;
    e.err = timeout;
    e.bcd = (timeout != 0) ? 24'hFFFFFF : to_bcd(sat);
    sb.push_back(e);
  endfunction

  task automatic set_op(input int idx, input int value);
    bus.bin_in[idx*DATA_W +: DATA_W] = DATA_W'(value);
  endtask

  task automatic check_reset_state(input string tag);
    check_val($sformatf("%s_ack", tag),        32'(bus.ack),        0);
    check_val($sformatf("%s_bcd_valid", tag),  32'(bus.bcd_valid),  0);
    check_val($sformatf("%s_busy", tag),       32'(bus.busy),       0);
    check_val($sformatf("%s_conv_start", tag), 32'(bus.conv_start), 0);
    check_val($sformatf("%s_bcd_out", tag),    32'(bus.bcd_out),    0);
    check_val($sformatf("%s_bcd_id", tag),     32'(bus.bcd_id),     0);
    check_val($sformatf("%s_ovf", tag),        32'(bus.ovf),        0);
    check_val($sformatf("%s_err", tag),        32'(bus.err),        0);
    check_val($sformatf("%s_conv_data", tag),  32'(bus.conv_data),  0);
  endtask

  // Wait for n completions; cycles counts negedges from the call to the last one.
  task automatic run_acks(input int n, input bit hold, input int budget, output int cycles);
    int got;
    got    = 0;
    cycles = 0;
    while (got < n && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (bus.bcd_valid === 1'b1) begin
        got++;
        if (!hold) bus.req[bus.bcd_id] = 1'b0;
      end
    end
    if (got < n) check_val("ack_wait_expired", 32'(got), 32'(n));
  endtask

  // Behavioural converter: optional stray done during START, optional silence to force a timeout.
  initial begin : converter
    int op;
    int silent_seen;
    int stray_seen;
    silent_seen  = 0;
    stray_seen   = 0;
    done_model   = 1'b0;
    bus.conv_bcd = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.conv_start === 1'b1) begin
        op      = int'(bus.conv_data);
        last_op = op;
        if (stray_seen != stray_req) begin
          stray_seen++;
          done_model   = 1'b1;
          bus.conv_bcd = 24'hABCDEF;
        end
        @(posedge clk);
        #1;
        done_model = 1'b0;
        repeat (conv_delay - 1) begin
          @(posedge clk);
          #1;
        end
        if (silent_seen != silent_req) begin
          silent_seen++;
        end else begin
          if (bus.busy === 1'b1) check_val("conv_data_stable", 32'(bus.conv_data), 32'(op));
          bus.conv_bcd = to_bcd(op);
          done_model   = 1'b1;
          @(posedge clk);
          #1;
          done_model = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.bcd_valid === 1'b1) begin
        n_valid++;
        if (sb.size() == 0) begin
          check_val("unexpected_valid", 32'(bus.bcd_valid), 0);
        end else begin
          e = sb.pop_front();
          $display("txn id=%0d bcd=%06h ovf=%0d err=%0d conv_data=%0d", bus.bcd_id, bus.bcd_out,
                   bus.ovf, bus.err, last_op);
          check_val("bcd_id",    32'(bus.bcd_id),  32'(e.id));
          check_val("ack",       32'(bus.ack),     32'(1 << e.id));
          check_val("bcd_out",   32'(bus.bcd_out), 32'(e.bcd));
          check_val("ovf",       32'(bus.ovf),     32'(e.ovf));
          check_val("err",       32'(bus.err),     32'(e.err));
          check_val("conv_data", 32'(last_op),     32'(e.op));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cyc;
    int nv;
    rst_n      = 1'b0;
    bus.req    = '0;
    bus.bin_in = '0;
    done_stim  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, 44-cycle converter; cycle in which req is first seen counts as cycle 1.
    set_op(0, 123456);
    conv_delay = 44;
    push_exp(0, 123456, 0);
    bus.req = 4'b0001;
    run_acks(1, 1'b0, 200, cyc);
    check_val("latency_conv44", 32'(cyc + 1), 32'(4 + 44));
    repeat (3) @(negedge clk);
    check_val("hold_bcd_out", 32'(bus.bcd_out), 32'h123456);
    check_val("hold_bcd_id",  32'(bus.bcd_id),  0);

    // Reset while requester 2 is in WAIT; the late conv_done must be ignored.
    set_op(2, 54321);
    conv_delay = 30;
    bus.req = 4'b0100;
    cyc = 0;
    while (bus.conv_start !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check_val("abort_start_seen", 32'(bus.conv_start), 1);
    repeat (10) @(negedge clk);
    #2;
    rst_n   = 1'b0;
    bus.req = '0;
    #1;
    check_val("abort_busy_in_reset", 32'(bus.busy),      0);
    check_val("abort_ack_in_reset",  32'(bus.ack),       0);
    check_val("abort_valid_in_reset", 32'(bus.bcd_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = n_valid;
    repeat (40) @(negedge clk);
    check_val("abort_no_ack",    32'(n_valid),  32'(nv));
    check_val("abort_busy_idle", 32'(bus.busy), 0);

    // Pointer back at 0: requester 0 must win over 1; 999999 is the largest unsaturated value.
    set_op(0, 7);
    set_op(1, 999999);
    conv_delay = 2;
    push_exp(0, 7, 0);
    push_exp(1, 999999, 0);
    bus.req = 4'b0011;
    run_acks(2, 1'b0, 300, cyc);

    // Saturated operand.
    set_op(2, 1048575);
    conv_delay = 3;
    push_exp(2, 1048575, 0);
    bus.req = 4'b0100;
    run_acks(1, 1'b0, 200, cyc);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("rst2");
    rst_n = 1'b1;
    @(negedge clk);

    // All four held after reset: 0,1,2,3,0.
    set_op(0, 11);
    set_op(1, 222222);
    set_op(2, 1000000);
    set_op(3, 500000);
    conv_delay = 7;
    push_exp(0, 11, 0);
    push_exp(1, 222222, 0);
    push_exp(2, 1000000, 0);
    push_exp(3, 500000, 0);
    push_exp(0, 11, 0);
    bus.req = 4'b1111;
    run_acks(5, 1'b1, 400, cyc);
    bus.req = '0;
    @(negedge clk);

    // Silent converter for requester 1, then requester 0 served normally.
    set_op(0, 42);
    set_op(1, 99);
    silent_req++;
    conv_delay = 3;
    push_exp(1, 99, 1);
    push_exp(0, 42, 0);
    bus.req = 4'b0011;
    run_acks(1, 1'b0, 200, cyc);
    check_val("latency_timeout", 32'(cyc + 1), 32'(4 + TIMEOUT));
    run_acks(1, 1'b0, 200, cyc);

    // Stray conv_done in IDLE and in START.
    @(negedge clk);
    nv = n_valid;
    done_stim = 1'b1;
    @(negedge clk);
    done_stim = 1'b0;
    repeat (3) @(negedge clk);
    check_val("idle_stray_ignored", 32'(n_valid), 32'(nv));
    stray_req++;
    conv_delay = 5;
    set_op(3, 654321);
    push_exp(3, 654321, 0);
    bus.req = 4'b1000;
    run_acks(1, 1'b0, 100, cyc);

    repeat (2) @(negedge clk);
    check_val("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
